// File: rtl/sensor_height_collector_if.sv
// Stream bundle for sensor_height_collector: sample input and height output
// handshakes plus the debug status outputs. The slave modport is the collector
// view; the master modport is the sensor/consumer environment view.
interface sensor_height_collector_if #(
  parameter int DATA_W = 8
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_height;
  logic [15:0]       frame_cnt;
  logic              timeout;

  modport slave (
    input  s_valid,
    input  s_data,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_height,
    output frame_cnt,
    output timeout
  );

  modport master (
    output s_valid,
    output s_data,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_height,
    input  frame_cnt,
    input  timeout
  );
endinterface

// File: rtl/sensor_height_collector.sv
// sensor_height_collector
//  Collects four serial height samples per frame (sensor1..sensor4), applies the
//  zero-sensor exclusion rule and presents one rounded height in a valid/ready
//  output register. frame_cnt counts delivered heights and saturates.
//  Optional feature macro: SENSOR_TIMEOUT_EN
//   defined   -> an idle watchdog drops a partial frame after TIMEOUT_CYCLES idle
//                cycles and pulses timeout for one cycle.
//   undefined -> a partial frame waits indefinitely; timeout is constant 0.
module sensor_height_collector #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  sensor_height_collector_if.slave bus
);

  localparam int SUM_W = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CALC    = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_idx;
  logic [1:0]        w_idx_nxt;
  logic [1:0]        w_idx_base;
  logic [DATA_W-1:0] r_s1;
  logic [DATA_W-1:0] r_s2;
  logic [DATA_W-1:0] r_s3;
  logic [DATA_W-1:0] r_s4;
  logic [DATA_W-1:0] w_s1_nxt;
  logic [DATA_W-1:0] w_s2_nxt;
  logic [DATA_W-1:0] w_s3_nxt;
  logic [DATA_W-1:0] w_s4_nxt;
  logic              r_s_ready;
  logic              w_s_ready_nxt;
  logic              r_m_valid;
  logic              w_m_valid_nxt;
  logic [DATA_W-1:0] r_m_height;
  logic [DATA_W-1:0] w_m_height_nxt;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       w_frame_cnt_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic              w_accept;

`ifdef SENSOR_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic              w_idle_expired;

  assign w_idle_expired = (r_idle == IDLE_W'(TIMEOUT_CYCLES));
`endif

  // Height rule: a zero on sensor1 or sensor3 marks that pair unusable and the
  // other pair is averaged; likewise for sensor2/sensor4; otherwise all four.
  // Sums are two bits wider than a sample, so rounding never wraps.
  function automatic logic [DATA_W-1:0] f_height(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] d
  );
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] quo;
    if ((a == {DATA_W{1'b0}}) || (c == {DATA_W{1'b0}})) begin
      sum = SUM_W'(b) + SUM_W'(d) + SUM_W'(2'd1);
      quo = sum >> 1;
    end else if ((b == {DATA_W{1'b0}}) || (d == {DATA_W{1'b0}})) begin
      sum = SUM_W'(a) + SUM_W'(c) + SUM_W'(2'd1);
      quo = sum >> 1;
    end else begin
      sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d) + SUM_W'(2'd2);
      quo = sum >> 2;
    end
    return quo[DATA_W-1:0];
  endfunction

  assign w_accept = bus.s_valid & r_s_ready;

  // Next-state, sample capture and output-register next values
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_idx_base      = r_idx;
    w_s1_nxt        = r_s1;
    w_s2_nxt        = r_s2;
    w_s3_nxt        = r_s3;
    w_s4_nxt        = r_s4;
    w_m_valid_nxt   = r_m_valid;
    w_m_height_nxt  = r_m_height;
    w_frame_cnt_nxt = r_frame_cnt;
`ifdef SENSOR_TIMEOUT_EN
    w_timeout_nxt   = 1'b0;
    w_idle_nxt      = r_idle;
`else
    // No idle watchdog in this build: the expression is constant zero.
    w_timeout_nxt   = (TIMEOUT_CYCLES < 32'sd0);
`endif

    case (r_state)
      ST_COLLECT: begin
`ifdef SENSOR_TIMEOUT_EN
        // Watchdog restarts the frame first, so a sample on the same edge
        // lands as sensor1 of the new frame.
        if (w_idle_expired) begin
          w_idx_base    = 2'd0;
          w_timeout_nxt = 1'b1;
          w_idle_nxt    = {IDLE_W{1'b0}};
        end else if (r_idx != 2'd0) begin
          w_idle_nxt = r_idle + IDLE_W'(1'b1);
        end else begin
          w_idle_nxt = {IDLE_W{1'b0}};
        end
`endif
        if (w_accept) begin
          case (w_idx_base)
            2'd0:    w_s1_nxt = bus.s_data;
            2'd1:    w_s2_nxt = bus.s_data;
            2'd2:    w_s3_nxt = bus.s_data;
            2'd3:    w_s4_nxt = bus.s_data;
            default: w_s1_nxt = bus.s_data;
          endcase
`ifdef SENSOR_TIMEOUT_EN
          w_idle_nxt = {IDLE_W{1'b0}};
`endif
          if (w_idx_base == 2'd3) begin
            w_idx_nxt   = 2'd0;
            w_state_nxt = ST_CALC;
          end else begin
            w_idx_nxt = w_idx_base + 2'd1;
          end
        end else begin
          w_idx_nxt = w_idx_base;
        end
      end

      ST_CALC: begin
        w_m_height_nxt = f_height(r_s1, r_s2, r_s3, r_s4);
        w_m_valid_nxt  = 1'b1;
        w_state_nxt    = ST_OUT;
      end

      ST_OUT: begin
        if (bus.m_ready) begin
          w_m_valid_nxt = 1'b0;
          w_state_nxt   = ST_COLLECT;
          if (r_frame_cnt != 16'hFFFF) begin
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt;
          end
        end else begin
          w_m_valid_nxt = r_m_valid;
        end
      end

      default: begin
        w_state_nxt   = ST_COLLECT;
        w_idx_nxt     = 2'd0;
        w_m_valid_nxt = 1'b0;
      end
    endcase

    w_s_ready_nxt = (w_state_nxt == ST_COLLECT);
  end

  // State, captured samples and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_idx       <= 2'd0;
      r_s1        <= {DATA_W{1'b0}};
      r_s2        <= {DATA_W{1'b0}};
      r_s3        <= {DATA_W{1'b0}};
      r_s4        <= {DATA_W{1'b0}};
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_m_height  <= {DATA_W{1'b0}};
      r_frame_cnt <= 16'h0000;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_s1        <= w_s1_nxt;
      r_s2        <= w_s2_nxt;
      r_s3        <= w_s3_nxt;
      r_s4        <= w_s4_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_m_height  <= w_m_height_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

`ifdef SENSOR_TIMEOUT_EN
  // Idle watchdog counter for partial frames
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= {IDLE_W{1'b0}};
    end else begin
      r_idle <= w_idle_nxt;
    end
  end
`endif

  assign bus.s_ready   = r_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_height  = r_m_height;
  assign bus.frame_cnt = r_frame_cnt;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_sensor_height_collector.sv
// Scoreboard bench for sensor_height_collector: a driver feeds samples and a
// reference model pushes expected heights; a monitor pops and compares them
// whenever the collector raises m_valid.
module tb_sensor_height_collector;
  localparam int DATA_W = 8;
  localparam int TO     = 10;

  typedef struct {
    int h;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ready_mode = 0;   // 0 random, 1 always ready, 2 never ready
  int   exp_cnt = 0;
  int   exp_to = 0;
  int   obs_to = 0;
  int   idle = 0;
  int   part[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sensor_height_collector_if #(.DATA_W(DATA_W)) bus ();

  sensor_height_collector #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Height rule straight from the sensor-exclusion definition.
  function automatic int ref_height(input int a, input int b, input int c, input int d);
    if (a == 0 || c == 0) return (b + d + 1) / 2;
    if (b == 0 || d == 0) return (a + c + 1) / 2;
    return (a + b + c + d + 2) / 4;
  endfunction

  // Effect of the coming clock edge on the frame being assembled.
  task automatic model_edge(input bit acc, input int d);
    bit to_now;
    to_now = 1'b0;
    if (bus.s_ready) begin
`ifdef SENSOR_TIMEOUT_EN
      if (part.size() != 0 && idle == TO) begin
        part.delete();
        idle = 0;
        to_now = 1'b1;
        exp_to++;
      end
`endif
      if (acc) begin
        part.push_back(d);
        idle = 0;
        if (part.size() == 4) begin
          // The height is seen on the second edge after this handshake edge.
          exp_q.push_back('{ref_height(part[0], part[1], part[2], part[3]), cyc + 2});
          part.delete();
        end
      end else if (!to_now && part.size() != 0) begin
        idle++;
      end
    end
  endtask

  task automatic step(input bit v, input int d, output bit acc);
    bus.s_valid = v;
    bus.s_data  = DATA_W'(d);
    acc = v && bus.s_ready;
    model_edge(acc, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    bit acc;
    repeat (n) step(1'b0, 0, acc);
  endtask

  task automatic send(input int d, input int gap);
    bit acc;
    int n;
    idle_n(gap);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      step(1'b1, d, acc);
      n++;
    end
    if (!acc) chk("send_accept_budget", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d);
    send(a, 0);
    send(b, 0);
    send(c, 0);
    send(d, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && n < 300) begin
      idle_n(1);
      n++;
    end
    if (n >= 300) chk("drain_budget", 32'd0, 32'd1);
  endtask

  function automatic int rnd_sample();
    int r;
    r = $urandom_range(7, 0);
    if (r == 0) return 0;
    if (r == 1) return 255;
    return $urandom_range(255, 0);
  endfunction

  // Downstream ready driver
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1)      bus.m_ready = 1'b1;
      else if (ready_mode == 2) bus.m_ready = 1'b0;
      else                      bus.m_ready = ($urandom_range(3, 0) != 0);
    end
  end

  // Output monitor: pops the scoreboard on each new height and checks holds
  initial begin
    bit   prev_mv;
    bit   pend;
    logic [DATA_W-1:0] held_h;
    exp_t e;
    prev_mv = 1'b0;
    pend    = 1'b0;
    held_h  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_mv = 1'b0;
        pend    = 1'b0;
        exp_cnt = 0;
      end else begin
        if (bus.timeout === 1'b1) obs_to++;
        if (pend) begin
          chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
          chk("s_ready_after_xfer", 32'(bus.s_ready), 32'd1);
          pend = 1'b0;
        end
        if (bus.m_valid && !prev_mv) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_m_valid", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("m_height", 32'(bus.m_height), 32'(e.h));
            chk("latency", 32'(cyc), 32'(e.c));
          end
          chk("s_ready_busy", 32'(bus.s_ready), 32'd0);
          held_h = bus.m_height;
        end else if (bus.m_valid) begin
          chk("m_height_hold", 32'(bus.m_height), 32'(held_h));
          chk("s_ready_busy", 32'(bus.s_ready), 32'd0);
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_cnt < 65535) exp_cnt++;
          pend = 1'b1;
        end
        prev_mv = bus.m_valid;
      end
    end
  end

  // Run-time bound
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Main stimulus
  initial begin
    bit acc;
    int to_before;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_height", 32'(bus.m_height), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    rst = 1'b0;

    // Basic frame with an always-ready consumer
    ready_mode = 1;
    send_frame(10, 20, 30, 40);
    drain();
    idle_n(1);
    chk("frame_cnt_first", 32'(bus.frame_cnt), 32'd1);

    // Exclusion and boundary frames
    send_frame(0, 20, 30, 40);
    send_frame(10, 0, 30, 40);
    send_frame(1, 2, 1, 2);
    send_frame(255, 255, 255, 255);
    send_frame(0, 0, 0, 0);
    drain();

    // Backpressure: height held, offered samples not consumed
    ready_mode = 2;
    send_frame(50, 60, 70, 80);
    begin
      int n;
      n = 0;
      while (!bus.m_valid && n < 20) begin
        idle_n(1);
        n++;
      end
    end
    repeat (5) begin
      step(1'b1, 99, acc);
      chk("bp_no_accept", 32'(acc), 32'd0);
    end
    ready_mode = 1;
    idle_n(1);
    drain();
    idle_n(2);

    // Reset in the middle of a frame drops the partial samples
    send(100, 0);
    send(200, 0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    part.delete();
    idle = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    send_frame(4, 4, 8, 8);
    drain();

    // Idle gap in a partial frame
    to_before = obs_to;
    send(1, 0);
    send(2, 0);
    idle_n(14);
`ifdef SENSOR_TIMEOUT_EN
    chk("timeout_pulse", 32'(obs_to - to_before), 32'd1);
    send_frame(8, 8, 8, 8);
`else
    chk("timeout_pulse", 32'(obs_to - to_before), 32'd0);
    send(8, 0);
    send(8, 0);
`endif
    drain();

    // Randomized frames, gaps and backpressure
    ready_mode = 0;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 4; k++) begin
        send(rnd_sample(), ($urandom_range(7, 0) == 0) ? $urandom_range(15, 0)
                                                      : $urandom_range(2, 0));
      end
    end
    drain();
    idle_n(15);
    drain();

    // Saturation of the delivered-frame counter
    ready_mode = 1;
    idle_n(2);
    force dut.r_frame_cnt = 16'hFFFE;
    idle_n(1);
    release dut.r_frame_cnt;
    exp_cnt = 65534;
    for (int f = 0; f < 3; f++) begin
      send_frame(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
    end
    drain();
    idle_n(2);
    chk("frame_cnt_sat", 32'(bus.frame_cnt), 32'hFFFF);

    chk("timeout_total", 32'(obs_to), 32'(exp_to));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
